// File: rtl/run_detector.sv
// Multi-lane run-length detector: each lane counts consecutive valid samples equal to
// target_bit and raises a level/pulse once the run reaches the threshold.
module run_detector #(
    parameter int CHANNELS = 4,
    parameter int RUN_W    = 4,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       sample,
    input  logic                      sample_valid,
    input  logic                      target_bit,
    input  logic [RUN_W-1:0]          threshold,
    input  logic                      clear,
    output logic [CHANNELS-1:0]       detection,
    output logic [CHANNELS-1:0]       det_pulse,
    output logic [CHANNELS*CNT_W-1:0] event_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DET   = 2'd2
    } state_t;

    localparam logic [RUN_W-1:0] RC_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              r_state     [CHANNELS];
    state_t              w_state_nxt [CHANNELS];
    logic [RUN_W-1:0]    r_rc        [CHANNELS];
    logic [RUN_W-1:0]    w_rc_nxt    [CHANNELS];
    logic [CNT_W-1:0]    r_cnt       [CHANNELS];
    logic [CNT_W-1:0]    w_cnt_nxt   [CHANNELS];
    logic [CHANNELS-1:0] r_det;
    logic [CHANNELS-1:0] r_pulse;
    logic [CHANNELS-1:0] w_det_nxt;
    logic [CHANNELS-1:0] w_pulse_nxt;
    logic [RUN_W-1:0]    w_thr;

    // Effective threshold: zero is treated as one.
    always_comb begin
        if (threshold == '0) begin
            w_thr = RUN_W'(1);
        end else begin
            w_thr = threshold;
        end
    end

    // Per-lane next-state logic; everything holds on non-valid cycles.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_rc_nxt[i]    = r_rc[i];
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_det_nxt[i]   = r_det[i];
            w_pulse_nxt[i] = 1'b0;
            if (sample_valid) begin
                if (sample[i] == target_bit) begin
                    if (r_rc[i] == RC_MAX) begin
                        w_rc_nxt[i] = RC_MAX;
                    end else begin
                        w_rc_nxt[i] = r_rc[i] + RUN_W'(1);
                    end
                    // Once in DET only a mismatch exits, so a raised threshold cannot drop the lane.
                    if ((r_state[i] == ST_DET) || (w_rc_nxt[i] >= w_thr)) begin
                        w_state_nxt[i] = ST_DET;
                    end else begin
                        w_state_nxt[i] = ST_COUNT;
                    end
                end else begin
                    w_rc_nxt[i]    = '0;
                    w_state_nxt[i] = ST_IDLE;
                end
                w_det_nxt[i]   = (w_state_nxt[i] == ST_DET);
                w_pulse_nxt[i] = w_det_nxt[i] && (r_state[i] != ST_DET);
                if (w_pulse_nxt[i] && (r_cnt[i] != CNT_MAX)) begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end else begin
                    w_cnt_nxt[i] = r_cnt[i];
                end
            end else begin
                w_pulse_nxt[i] = 1'b0;
            end
        end
    end

    // State and output registers with async reset and synchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= ST_IDLE;
                r_rc[i]    <= '0;
                r_cnt[i]   <= '0;
            end
            r_det   <= '0;
            r_pulse <= '0;
        end else if (clear) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= ST_IDLE;
                r_rc[i]    <= '0;
                r_cnt[i]   <= '0;
            end
            r_det   <= '0;
            r_pulse <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_rc[i]    <= w_rc_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_det   <= w_det_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    // Flatten per-lane counters onto the output bus.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            event_count[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end

    assign detection = r_det;
    assign det_pulse = r_pulse;

endmodule

// File: tb/tb_run_detector.sv
// Directed and randomized bench for run_detector against a run-length reference model.
module tb_run_detector;

    localparam int CH    = 4;
    localparam int RUN_W = 4;
    localparam int CNT_W = 2;
    localparam int RMAX  = 15;
    localparam int CMAX  = 3;

    logic                   clk;
    logic                   reset_n;
    logic [CH-1:0]          sample;
    logic                   sample_valid;
    logic                   target_bit;
    logic [RUN_W-1:0]       threshold;
    logic                   clear;
    logic [CH-1:0]          detection;
    logic [CH-1:0]          det_pulse;
    logic [CH*CNT_W-1:0]    event_count;

    int n_checks;
    int n_pass;
    int n_fail;

    int m_run [CH];
    bit m_det [CH];
    bit m_pul [CH];
    int m_cnt [CH];

    run_detector #(.CHANNELS(CH), .RUN_W(RUN_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .target_bit   (target_bit),
        .threshold    (threshold),
        .clear        (clear),
        .detection    (detection),
        .det_pulse    (det_pulse),
        .event_count  (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_zero();
        for (int i = 0; i < CH; i++) begin
            m_run[i] = 0;
            m_det[i] = 1'b0;
            m_pul[i] = 1'b0;
            m_cnt[i] = 0;
        end
    endfunction

    // One clock edge of the reference: a lane is detected while its run has reached the
    // threshold at some point and no mismatch has broken it since.
    function automatic void model_step(input bit clr, input bit v, input logic [CH-1:0] s,
                                       input bit tgt, input int thr_in);
        int thr_eff;
        bit now_det;
        thr_eff = (thr_in == 0) ? 1 : thr_in;
        if (clr) begin
            model_zero();
        end else begin
            for (int i = 0; i < CH; i++) begin
                m_pul[i] = 1'b0;
                if (v) begin
                    if (s[i] == tgt) begin
                        m_run[i] = (m_run[i] < RMAX) ? m_run[i] + 1 : RMAX;
                        now_det  = m_det[i] || (m_run[i] >= thr_eff);
                    end else begin
                        m_run[i] = 0;
                        now_det  = 1'b0;
                    end
                    m_pul[i] = now_det && !m_det[i];
                    if (m_pul[i]) m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                    m_det[i] = now_det;
                end
            end
        end
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] e_det;
        logic [31:0] e_pul;
        logic [31:0] e_cnt;
        e_det = '0;
        e_pul = '0;
        e_cnt = '0;
        for (int i = 0; i < CH; i++) begin
            e_det[i] = m_det[i];
            e_pul[i] = m_pul[i];
            e_cnt = e_cnt | (32'(m_cnt[i]) << (i * CNT_W));
        end
        check({tag, ".det"}, 32'(detection), e_det);
        check({tag, ".pulse"}, 32'(det_pulse), e_pul);
        check({tag, ".count"}, 32'(event_count), e_cnt);
    endtask

    task automatic step(input string tag, input logic v, input logic [CH-1:0] s, input logic clr);
        sample_valid = v;
        sample       = s;
        clear        = clr;
        @(posedge clk);
        model_step(clr, v, s, target_bit, int'(threshold));
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [CH-1:0] rs;
        logic [CH-1:0] z6 [6];
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        model_zero();
        reset_n      = 1'b0;
        sample       = 4'b0000;
        sample_valid = 1'b0;
        target_bit   = 1'b0;
        threshold    = 4'd2;
        clear        = 1'b0;
        #2;
        check("reset.async_det", 32'(detection), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // Two-consecutive-zero detector on lane 0; other lanes see ones.
        z6[0] = 4'b1110; z6[1] = 4'b1111; z6[2] = 4'b1110;
        z6[3] = 4'b1110; z6[4] = 4'b1110; z6[5] = 4'b1111;
        for (int k = 0; k < 6; k++) step($sformatf("zero2.s%0d", k), 1'b1, z6[k], 1'b0);
        check("zero2.cnt0", 32'(event_count[1:0]), 32'd1);

        step("clr1", 1'b0, 4'b0000, 1'b1);

        // Threshold 0 acts as 1.
        threshold  = 4'd0;
        target_bit = 1'b1;
        step("thr0", 1'b1, 4'b0010, 1'b0);
        check("thr0.det1", 32'(detection[1]), 32'd1);
        check("thr0.pulse1", 32'(det_pulse[1]), 32'd1);
        step("clr2", 1'b0, 4'b0000, 1'b1);

        // Gapped valid: only valid cycles advance the run.
        threshold = 4'd3;
        for (int k = 0; k < 5; k++) step($sformatf("gap.s%0d", k), (k % 2 == 0), 4'b1111, 1'b0);
        check("gap.det_after3", 32'(detection), 32'hF);
        step("clr3", 1'b0, 4'b0000, 1'b1);

        // Six separate runs on lane 0 saturate the 2-bit counter.
        threshold = 4'd1;
        for (int k = 0; k < 6; k++) begin
            step($sformatf("sat.hit%0d", k), 1'b1, 4'b0001, 1'b0);
            step($sformatf("sat.brk%0d", k), 1'b1, 4'b0000, 1'b0);
        end
        check("sat.cnt0", 32'(event_count[1:0]), 32'd3);
        step("clr4", 1'b0, 4'b0000, 1'b1);

        // All lanes enter DET together.
        step("all4", 1'b1, 4'b1111, 1'b0);
        check("all4.det", 32'(detection), 32'hF);
        check("all4.pulse", 32'(det_pulse), 32'hF);
        step("all4.hold", 1'b1, 4'b1111, 1'b0);

        // Clear beats valid while in DET.
        step("clrvalid", 1'b1, 4'b1111, 1'b1);
        check("clrvalid.det", 32'(detection), 32'd0);

        // Asynchronous reset mid-run, between edges.
        threshold = 4'd2;
        step("rst.pre0", 1'b1, 4'b1111, 1'b0);
        step("rst.pre1", 1'b1, 4'b1111, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_zero();
        check("rst.async_det", 32'(detection), 32'd0);
        check("rst.async_cnt", 32'(event_count), 32'd0);
        @(posedge clk);
        #1;
        check_all("rst.held");
        reset_n = 1'b1;
        step("rst.post1", 1'b1, 4'b1111, 1'b0);
        step("rst.post2", 1'b1, 4'b1111, 1'b0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            if ((k % 25) == 0) begin
                target_bit = 1'($urandom_range(0, 1));
                threshold  = 4'($urandom_range(0, 6));
            end
            for (int b = 0; b < CH; b++) begin
                rs[b] = ($urandom_range(0, 99) < 80) ? target_bit : ~target_bit;
            end
            step($sformatf("rnd%0d", k), ($urandom_range(0, 99) < 70), rs,
                 ($urandom_range(0, 99) < 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
